// File: rtl/reg_writeback_pkg.sv
// Shared types for the register-file write-back arbiter: register address/data,
// the LU result FIFO entry and the arbiter state encoding.
package reg_writeback_pkg;

    typedef logic        Bit_t;
    typedef logic [4:0]  Reg_addr_t;
    typedef logic [31:0] Reg_data_t;

    localparam Bit_t      ENABLE    = 1'b1;
    localparam Bit_t      DISABLE   = 1'b0;
    localparam Reg_addr_t REG_ZERO  = 5'd0;
    localparam Reg_data_t ZERO_WORD = 32'd0;

    typedef struct packed {
        Reg_addr_t addr;
        Reg_data_t data;
    } Wb_entry_t;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        LU_PRI   = 1'b1
    } Wb_state_t;

    function automatic logic [31:0] addr_bit(input Reg_addr_t a);
        return 32'd1 << a;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// Small power-of-two FIFO of write-back entries; head is presented combinationally,
// occupancy is a registered count with derived full/empty flags.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  Wb_entry_t                din,
    output Wb_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    Wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back arbiter for the register file's single write port: merges pipeline WB
// results with buffered long-latency results. Optional macro WB_LU_BYPASS_EN lets an
// LU result skip the empty FIFO when the pipeline is idle.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_waddr,
    input  logic [31:0]                   pipe_wdata,
    output logic                          pipe_stall,
    input  logic                          lu_issue,
    input  logic [4:0]                    lu_issue_addr,
    input  logic                          lu_valid,
    input  logic [4:0]                    lu_addr,
    input  logic [31:0]                   lu_data,
    output logic                          lu_ready,
    output logic                          write_enable,
    output logic [4:0]                    write_addr,
    output logic [31:0]                   write_data,
    output logic [31:0]                   busy_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int             SW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_LAST = SW'(STARVE_LIMIT - 1);

    Wb_state_t      state;
    Wb_state_t      next_state;
    logic [SW-1:0]  starve_cnt;
    logic           starve_hit;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    Wb_entry_t      fifo_head;
    Wb_entry_t      lu_entry;
    logic           lu_fire;
    logic           bypass;

    logic           sel_we;
    Reg_addr_t      sel_addr;
    Reg_data_t      sel_data;
    logic [31:0]    busy_next;

    assign lu_ready   = !fifo_full;
    assign lu_fire    = lu_valid && lu_ready;
    assign lu_entry   = '{addr: lu_addr, data: lu_data};
    // Results for $zero complete the handshake but are dropped here.
    assign fifo_push  = lu_fire && (lu_addr != REG_ZERO) && !bypass;
    assign starve_hit = (state == PIPE_PRI) && pipe_we && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (lu_entry),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= PIPE_PRI;
        else      state <= next_state;
    end

    // LU_PRI is entered on the edge where the FIFO loses for the STARVE_LIMIT-th time.
    always_comb begin
        next_state = state;
        case (state)
            PIPE_PRI: if (starve_hit && starve_cnt == STARVE_LAST) next_state = LU_PRI;
            LU_PRI:   next_state = PIPE_PRI;
            default:  next_state = PIPE_PRI;
        endcase
    end

    always_comb begin
        pipe_stall = 1'b0;
        fifo_pop   = 1'b0;
        bypass     = 1'b0;
        sel_we     = 1'b0;
        sel_addr   = REG_ZERO;
        sel_data   = ZERO_WORD;
        case (state)
            LU_PRI: begin
                pipe_stall = 1'b1;
                fifo_pop   = !fifo_empty;
                sel_we     = !fifo_empty;
                sel_addr   = fifo_head.addr;
                sel_data   = fifo_head.data;
            end
            default: begin
                if (pipe_we) begin
                    sel_we   = (pipe_waddr != REG_ZERO);
                    sel_addr = pipe_waddr;
                    sel_data = pipe_wdata;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sel_we   = 1'b1;
                    sel_addr = fifo_head.addr;
                    sel_data = fifo_head.data;
                end
`ifdef WB_LU_BYPASS_EN
                else if (lu_fire) begin
                    bypass   = 1'b1;
                    sel_we   = (lu_addr != REG_ZERO);
                    sel_addr = lu_addr;
                    sel_data = lu_data;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          starve_cnt <= '0;
        else if (fifo_pop || fifo_empty)   starve_cnt <= '0;
        else if (starve_hit)               starve_cnt <= starve_cnt + 1'b1;
    end

    // Clears are applied before the set so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_next = busy_mask;
        if (fifo_pop) busy_next = busy_next & ~addr_bit(fifo_head.addr);
        if (bypass)   busy_next = busy_next & ~addr_bit(lu_addr);
        if (lu_issue && lu_issue_addr != REG_ZERO)
            busy_next = busy_next | addr_bit(lu_issue_addr);
    end

    // Output stage: selection made this cycle drives the register file next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_enable <= 1'b0;
            write_addr   <= REG_ZERO;
            write_data   <= ZERO_WORD;
            busy_mask    <= '0;
        end else begin
            write_enable <= sel_we;
            write_addr   <= sel_addr;
            write_data   <= sel_data;
            busy_mask    <= busy_next;
        end
    end

    a_pipe_not_busy: assert property (@(posedge clk) disable iff (!rst)
        (pipe_we && pipe_waddr != REG_ZERO) |-> !busy_mask[pipe_waddr]);

    a_lu_was_issued: assert property (@(posedge clk) disable iff (!rst)
        (lu_fire && lu_addr != REG_ZERO) |-> busy_mask[lu_addr]);

endmodule
